// File: rtl/hdmi_qsys_nios2_qsys_oci_dct_packer_pkg.sv
// hdmi_qsys_nios2_qsys_oci_dct_packer_pkg: shared DCT trace constants and packer states
package hdmi_qsys_nios2_qsys_oci_dct_packer_pkg;
    localparam int ATOM_W = 2;
    localparam int ATOMS = 15;
    localparam int BUF_W = ATOM_W * ATOMS;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(ATOMS);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, ENDED = 2'd2} state_t;
endpackage

// File: rtl/hdmi_qsys_nios2_qsys_oci_dct_packer_frame_reg.sv
// hdmi_qsys_oci_frame_reg: one-deep valid/ready output register
module hdmi_qsys_oci_frame_reg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         free
);
    assign free = !valid | ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            valid <= load | (valid & !ready);
            if (load) q <= d;
        end
    end
endmodule

// File: rtl/hdmi_qsys_nios2_qsys_oci_dct_packer.sv
// hdmi_qsys_nios2_qsys_oci_dct_packer: packs 2-bit trace atoms into 15-atom DCT frames
module hdmi_qsys_nios2_qsys_oci_dct_packer
    import hdmi_qsys_nios2_qsys_oci_dct_packer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    output logic              atom_ready,
    input  logic              flush,
    input  logic              test_ending,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              test_has_ended
);
    state_t state, state_n;
    logic [BUF_W-1:0] acc, m_acc, n_acc;
    logic [CNT_W-1:0] acc_cnt, m_cnt, n_cnt;
    logic flush_pend, n_pend, live, full, accept, flush_req, launch, out_free;
    assign full = acc_cnt == FULL;
    assign atom_ready = live & (state == RUN) & !(full & !out_free);
    assign accept = atom_valid & atom_ready;
    assign flush_req = flush | flush_pend | (state == DRAIN);
    assign test_has_ended = state == ENDED;
    // A full accumulator launches as-is; an atom taken in that cycle seeds the next frame.
    always_comb begin
        m_acc  = (full | !accept) ? acc : acc | (BUF_W'(atom_data) << (ATOM_W * acc_cnt));
        m_cnt  = full ? FULL : acc_cnt + CNT_W'(accept);
        launch = out_free & ((m_cnt == FULL) | (flush_req & (m_cnt != '0)));
        n_acc  = !launch ? m_acc : (full & accept) ? BUF_W'(atom_data) : '0;
        n_cnt  = !launch ? m_cnt : CNT_W'(full & accept);
        n_pend = !launch & (flush | flush_pend) & (m_cnt != '0);
    end
    always_comb begin
        state_n = (state == RUN & test_ending) ? DRAIN :
                  (state == DRAIN & acc_cnt == '0 & !frame_valid) ? ENDED : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
            live       <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= n_acc;
            acc_cnt    <= n_cnt;
            flush_pend <= n_pend;
            live       <= 1'b1;
        end
    end
    hdmi_qsys_oci_frame_reg #(.W(BUF_W + CNT_W)) u_frame_reg (
        .clk   (clk),
        .reset (reset),
        .load  (launch),
        .d     ({m_cnt, m_acc}),
        .ready (frame_ready),
        .valid (frame_valid),
        .q     ({dct_count, dct_buffer}),
        .free  (out_free)
    );
endmodule

// File: tb/tb_hdmi_qsys_nios2_qsys_oci_dct_packer.sv
// tb_hdmi_qsys_nios2_qsys_oci_dct_packer: randomized scoreboard bench for the DCT packer
module tb_hdmi_qsys_nios2_qsys_oci_dct_packer;
    logic clk = 0, reset = 1, atom_valid = 0, flush = 0, test_ending = 0, frame_ready = 0;
    logic [1:0] atom_data = 0;
    logic atom_ready, frame_valid, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0] dct_count;
    int checks = 0, failures = 0;
    logic [1:0] cur[$];
    logic [33:0] exp_q[$], got_q[$];
    logic [29:0] mb, w;
    logic [1:0] src[45];
    int idx;

    hdmi_qsys_nios2_qsys_oci_dct_packer dut (
        .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom_data(atom_data),
        .atom_ready(atom_ready), .flush(flush), .test_ending(test_ending),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference: atoms group into frames of 15, cut early by flush or end-of-test.
    always @(negedge clk) begin
        if (reset) cur.delete();
        else begin
            if (atom_valid && atom_ready) cur.push_back(atom_data);
            if (cur.size() == 15 || ((flush || test_ending) && cur.size() > 0)) begin
                mb = '0;
                foreach (cur[i]) mb[2*i +: 2] = cur[i];
                exp_q.push_back({4'(cur.size()), mb});
                cur.delete();
            end
            if (frame_valid && frame_ready) got_q.push_back({dct_count, dct_buffer});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        atom_valid = 0; flush = 0; test_ending = 0; frame_ready = 0;
        reset = 1;
        repeat (2) tick();
        reset = 0;
        got_q.delete();
        exp_q.delete();
        tick();
    endtask

    task automatic send_atom(input logic [1:0] d);
        int n;
        logic ok;
        n = 0;
        atom_valid = 1;
        atom_data = d;
        do begin
            @(negedge clk);
            ok = atom_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        checks++;
        if (!ok) begin failures++; $display("FAIL send_atom: accepted=%0b required=1", ok); end
        atom_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (atom_ready !== 0) begin failures++; $display("FAIL reset_atom_ready: got %0b want 0", atom_ready); end
        checks++; if (frame_valid !== 0) begin failures++; $display("FAIL reset_frame_valid: got %0b want 0", frame_valid); end
        checks++; if (dct_buffer !== 0) begin failures++; $display("FAIL reset_buffer: got %h want 0", dct_buffer); end
        checks++; if (dct_count !== 0) begin failures++; $display("FAIL reset_count: got %0d want 0", dct_count); end
        checks++; if (test_has_ended !== 0) begin failures++; $display("FAIL reset_ended: got %0b want 0", test_has_ended); end
        tick();
        reset = 0;
        @(negedge clk);
        checks++; if (atom_ready !== 0) begin failures++; $display("FAIL release_ready_early: got %0b want 0", atom_ready); end
        @(negedge clk);
        checks++; if (atom_ready !== 1) begin failures++; $display("FAIL release_ready: got %0b want 1", atom_ready); end
        tick();
    endtask

    task automatic test_full_frame();
        do_reset();
        frame_ready = 1;
        w = '0;
        for (int k = 0; k < 15; k++) begin
            w[2*k +: 2] = 2'(k % 4);
            send_atom(2'(k % 4));
        end
        checks++; if (frame_valid !== 1 || dct_count !== 15) begin failures++; $display("FAIL full_latency: valid=%0b count=%0d want 1/15", frame_valid, dct_count); end
        checks++; if (dct_buffer !== w) begin failures++; $display("FAIL full_buffer: got %h want %h", dct_buffer, w); end
        repeat (3) tick();
        checks++; if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin failures++; $display("FAIL full_model: got %0d frames want 1", got_q.size()); end
    endtask

    task automatic test_flush();
        do_reset();
        frame_ready = 1;
        send_atom(3); send_atom(1); send_atom(2);
        flush = 1; tick(); flush = 0;
        repeat (3) tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== {4'd3, 30'h27}) begin failures++; $display("FAIL flush_partial: frames=%0d first=%h want 1/%h", got_q.size(), got_q[0], {4'd3, 30'h27}); end
        checks++; if (exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin failures++; $display("FAIL flush_model: got %h want %h", got_q[0], exp_q[0]); end
        got_q.delete();
        flush = 1; tick(); flush = 0;
        repeat (3) tick();
        checks++; if (got_q.size() != 0 || frame_valid !== 0) begin failures++; $display("FAIL flush_empty: frames=%0d valid=%0b want 0/0", got_q.size(), frame_valid); end
    endtask

    task automatic offer(input int lim);
        int n;
        logic ok;
        n = 0;
        while (idx < lim && n < 200) begin
            atom_valid = 1;
            atom_data = src[idx];
            @(negedge clk);
            ok = atom_ready;
            tick();
            if (ok) idx++;
            n++;
        end
        atom_valid = 0;
        checks++; if (idx != lim) begin failures++; $display("FAIL offer_timeout: accepted %0d want %0d", idx, lim); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        foreach (src[i]) src[i] = 2'($urandom);
        idx = 0;
        offer(30);
        atom_valid = 1;
        atom_data = src[30];
        repeat (4) begin
            @(negedge clk);
            checks++; if (atom_ready !== 0) begin failures++; $display("FAIL stall_ready: got %0b want 0", atom_ready); end
            tick();
        end
        w = '0;
        for (int k = 0; k < 15; k++) w[2*k +: 2] = src[k];
        checks++; if (frame_valid !== 1 || dct_buffer !== w) begin failures++; $display("FAIL held_frame: valid=%0b buf=%h want 1/%h", frame_valid, dct_buffer, w); end
        frame_ready = 1;
        offer(45);
        repeat (5) tick();
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL b2b_frames: got %0d want 3", got_q.size()); end
        for (int f = 0; f < 3 && f < got_q.size(); f++) begin
            w = '0;
            for (int k = 0; k < 15; k++) w[2*k +: 2] = src[15*f + k];
            checks++; if (got_q[f] !== {4'd15, w}) begin failures++; $display("FAIL b2b_frame%0d: got %h want %h", f, got_q[f], {4'd15, w}); end
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (800) begin
            atom_valid = $urandom_range(0, 1) == 1;
            atom_data = 2'($urandom);
            frame_ready = ($urandom % 4) != 0;
            tick();
        end
        frame_ready = 1;
        repeat (600) begin
            atom_valid = $urandom_range(0, 2) != 0;
            atom_data = 2'($urandom);
            flush = ($urandom % 8) == 0;
            tick();
        end
        atom_valid = 0; flush = 1; tick(); flush = 0;
        repeat (5) tick();
        checks++; if (got_q.size() == 0 || got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int f = 0; f < got_q.size() && f < exp_q.size(); f++) begin
            checks++; if (got_q[f] !== exp_q[f]) begin failures++; $display("FAIL random_frame%0d: got %h want %h", f, got_q[f], exp_q[f]); end
        end
    endtask

    task automatic test_drain();
        int n;
        do_reset();
        for (int k = 0; k < 5; k++) send_atom(2'($urandom));
        test_ending = 1;
        repeat (4) tick();
        checks++; if (frame_valid !== 1 || dct_count !== 5) begin failures++; $display("FAIL drain_frame: valid=%0b count=%0d want 1/5", frame_valid, dct_count); end
        checks++; if (test_has_ended !== 0 || atom_ready !== 0) begin failures++; $display("FAIL drain_busy: ended=%0b ready=%0b want 0/0", test_has_ended, atom_ready); end
        frame_ready = 1;
        n = 0;
        while (!test_has_ended && n < 20) begin tick(); n++; end
        checks++; if (test_has_ended !== 1) begin failures++; $display("FAIL drain_ended: got %0b want 1", test_has_ended); end
        checks++; if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin failures++; $display("FAIL drain_model: got %h want %h", got_q[0], exp_q[0]); end
        test_ending = 0;
        atom_valid = 1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (atom_ready !== 0 || test_has_ended !== 1 || frame_valid !== 0) begin failures++; $display("FAIL ended_sticky: ready=%0b ended=%0b valid=%0b want 0/1/0", atom_ready, test_has_ended, frame_valid); end
        atom_valid = 0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 22; k++) send_atom(2'($urandom));
        checks++; if (frame_valid !== 1) begin failures++; $display("FAIL pre_reset_valid: got %0b want 1", frame_valid); end
        #2;
        reset = 1;
        #1;
        checks++; if (frame_valid !== 0 || dct_count !== 0 || dct_buffer !== 0 || atom_ready !== 0) begin failures++; $display("FAIL async_reset: valid=%0b count=%0d buf=%h ready=%0b want all 0", frame_valid, dct_count, dct_buffer, atom_ready); end
        tick();
        reset = 0;
        got_q.delete();
        exp_q.delete();
        tick();
        frame_ready = 1;
        w = '0;
        for (int k = 0; k < 15; k++) begin
            src[k] = 2'($urandom);
            w[2*k +: 2] = src[k];
            send_atom(src[k]);
        end
        repeat (3) tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== {4'd15, w}) begin failures++; $display("FAIL post_reset_frame: frames=%0d got %h want %h", got_q.size(), got_q[0], {4'd15, w}); end
    endtask

    task automatic test_flush_on_full();
        do_reset();
        frame_ready = 1;
        for (int k = 0; k < 14; k++) send_atom(2'($urandom));
        flush = 1;
        send_atom(2'($urandom));
        flush = 0;
        repeat (4) tick();
        checks++; if (got_q.size() != 1 || got_q[0][33:30] !== 4'd15) begin failures++; $display("FAIL flush_full: frames=%0d count=%0d want 1/15", got_q.size(), got_q[0][33:30]); end
        checks++; if (exp_q.size() != 1 || got_q[0] !== exp_q[0] || frame_valid !== 0) begin failures++; $display("FAIL flush_full_model: got %h want %h valid=%0b", got_q[0], exp_q[0], frame_valid); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_back_to_back();
        test_random();
        test_drain();
        test_async_reset();
        test_flush_on_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
